// File: rtl/hbm_write_traffic_gen_if.sv
// AXI3 write-only channel bundle (AW, W, B) between the traffic generator and one HBM pseudo-channel.
interface hbm_write_traffic_gen_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 33,
   parameter int ID_WIDTH   = 6
);
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [3:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/hbm_write_traffic_gen.sv
// AXI3 INCR write burst generator for HBM bandwidth runs: run-time burst count, pattern and
// outstanding limit, with a show-ahead pattern FIFO feeding the W channel.
//
// state  | meaning
// S_IDLE | waiting for start; config latched on start
// S_RUN  | issuing AW/W, collecting B until every burst is acknowledged
// S_DONE | one-cycle completion step; done stays set until the next start
module hbm_write_traffic_gen #(
   parameter int DATA_WIDTH      = 256,
   parameter int ADDR_WIDTH      = 33,
   parameter int ID_WIDTH        = 6,
   parameter int PORT_RANK       = 0,
   parameter int BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING = 8,
   parameter int FIFO_DEPTH      = 32,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [CNT_WIDTH-1:0]  cfg_num_bursts,
   input  logic [1:0]            cfg_mode,
   input  logic [31:0]           cfg_seed,
   hbm_write_traffic_gen_if.master axi,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CNT_WIDTH-1:0]  cycle_cnt,
   output logic [CNT_WIDTH-1:0]  beat_cnt
);
   localparam int BYTES       = DATA_WIDTH / 8;
   localparam int LANES       = DATA_WIDTH / 32;
   localparam int BURST_BYTES = BURST_LEN * BYTES;
   localparam int ALIGN       = $clog2(BURST_BYTES);
   localparam int PTR_W       = $clog2(FIFO_DEPTH);
   localparam int GEN_W       = CNT_WIDTH + 5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  num_bursts;
   logic [GEN_W-1:0]      gen_total;
   logic [GEN_W-1:0]      gen_cnt;
   logic [1:0]            mode;
   logic [31:0]           seed;
   logic [31:0]           lfsr;
   logic [CNT_WIDTH-1:0]  aw_cnt;
   logic [CNT_WIDTH-1:0]  b_cnt;
   logic [CNT_WIDTH-1:0]  w_burst_cnt;
   logic [3:0]            beat_idx;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [PTR_W:0]        wr_ptr;
   logic [PTR_W:0]        rd_ptr;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic                  run;
   logic [CNT_WIDTH-1:0]  outstanding;
   logic                  aw_valid;
   logic                  w_valid;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  aw_fire;
   logic                  w_fire;
   logic                  w_last;
   logic                  b_fire;
   logic                  push;
   logic [31:0]           lfsr_next;
   logic [DATA_WIDTH-1:0] gen_word;

   assign run         = (state == S_RUN);
   assign outstanding = aw_cnt - b_cnt;
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign aw_valid    = run && (aw_cnt < num_bursts) &&
                        (outstanding < CNT_WIDTH'(MAX_OUTSTANDING));
   // W beats of burst k wait until AW k has been accepted.
   assign w_valid     = run && !fifo_empty && (w_burst_cnt < aw_cnt);
   assign aw_fire     = aw_valid && axi.awready;
   assign w_fire      = w_valid && axi.wready;
   assign w_last      = (beat_idx == 4'(BURST_LEN - 1));
   assign b_fire      = axi.bvalid && busy;
   assign push        = run && (gen_cnt < gen_total) && (!fifo_full || w_fire);
   assign lfsr_next   = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

   always_comb begin
      gen_word = '0;
      for (int i = 0; i < LANES; i++) begin
         case (mode)
            2'd1:    gen_word[i*32 +: 32] = (seed + gen_cnt[31:0]) ^ 32'(i);
            2'd2:    gen_word[i*32 +: 32] = lfsr ^ 32'(i);
            default: gen_word[i*32 +: 32] = seed;
         endcase
      end
   end

   assign axi.awid    = ID_WIDTH'(PORT_RANK);
   assign axi.awaddr  = awaddr_q;
   assign axi.awlen   = busy ? 4'(BURST_LEN - 1) : 4'd0;
   assign axi.awsize  = busy ? 3'($clog2(BYTES)) : 3'd0;
   assign axi.awburst = busy ? 2'b01 : 2'b00;
   assign axi.awvalid = aw_valid;
   assign axi.wdata   = w_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;
   assign axi.wstrb   = w_valid ? '1 : '0;
   assign axi.wlast   = w_valid && w_last;
   assign axi.wvalid  = w_valid;
   assign axi.bready  = busy;

   always_ff @(posedge aclk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= gen_word;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         cycle_cnt   <= '0;
         beat_cnt    <= '0;
         num_bursts  <= '0;
         gen_total   <= '0;
         gen_cnt     <= '0;
         mode        <= 2'd0;
         seed        <= '0;
         lfsr        <= 32'h1;
         aw_cnt      <= '0;
         b_cnt       <= '0;
         w_burst_cnt <= '0;
         beat_idx    <= '0;
         awaddr_q    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_RUN;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  err         <= 1'b0;
                  cycle_cnt   <= '0;
                  beat_cnt    <= '0;
                  num_bursts  <= cfg_num_bursts;
                  gen_total   <= GEN_W'(cfg_num_bursts) * GEN_W'(BURST_LEN);
                  gen_cnt     <= '0;
                  mode        <= cfg_mode;
                  seed        <= cfg_seed;
                  lfsr        <= (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
                  aw_cnt      <= '0;
                  b_cnt       <= '0;
                  w_burst_cnt <= '0;
                  beat_idx    <= '0;
                  awaddr_q    <= {cfg_base_addr[ADDR_WIDTH-1:ALIGN], ALIGN'(0)};
                  wr_ptr      <= '0;
                  rd_ptr      <= '0;
               end
            end
            S_RUN: begin
               cycle_cnt <= cycle_cnt + 1'b1;
               if (aw_fire) begin
                  aw_cnt   <= aw_cnt + 1'b1;
                  awaddr_q <= awaddr_q + ADDR_WIDTH'(BURST_BYTES);
               end
               if (w_fire) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
                  if (w_last) begin
                     beat_idx    <= '0;
                     w_burst_cnt <= w_burst_cnt + 1'b1;
                  end else begin
                     beat_idx <= beat_idx + 1'b1;
                  end
               end
               if (push) begin
                  wr_ptr  <= wr_ptr + 1'b1;
                  gen_cnt <= gen_cnt + 1'b1;
                  lfsr    <= lfsr_next;
               end
               // An unsolicited B is flagged but never counted toward completion.
               if (b_fire) begin
                  if (axi.bresp != 2'b00) err <= 1'b1;
                  if (b_cnt == aw_cnt) err <= 1'b1;
                  else                 b_cnt <= b_cnt + 1'b1;
               end
               if (b_cnt == num_bursts) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
